// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode encodings and elaboration helpers for the fifo slice.
// No ports; imported by fifo and fifo_ram.
package fifo_pkg;

    // Head read modes selected by READ_CYCLES.
    localparam int unsigned RC_COMB = 0;
    localparam int unsigned RC_REG  = 1;

    // Elaboration-time check used for the DEPTH parameter.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port 1W/1R storage, DEPTH x BIT_WIDTH.
// Ports: clk_i; we_i/waddr_i/wdata_i write port;
//        re_i/raddr_i/rdata_o read port (async or registered).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned READ_CYCLES = 0,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [BIT_WIDTH-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [BIT_WIDTH-1:0] rdata_o
);

    logic [BIT_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    if (READ_CYCLES == RC_COMB) begin : g_comb_rd
        // Address alone selects the word; no read strobe needed.
        logic unused_re;
        assign unused_re = re_i;
        assign rdata_o   = mem_q[raddr_i];
    end else begin : g_reg_rd
        // Read register doubles as the fifo head register: it only
        // changes on a strobe, so the head stays stable between pops.
        logic [BIT_WIDTH-1:0] rdata_q;
        always_ff @(posedge clk_i) begin
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
        assign rdata_o = rdata_q;
    end

endmodule

// File: rtl/fifo.sv
// fifo: single-clock show-ahead FIFO; head word on out_data/out_valid.
// Ports: clk, rst (sync, active-high); in_valid/in_data push side;
//        out_enable pops head; out_valid/out_data head; full, empty.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned READ_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 out_enable,
    output logic                 out_valid,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $fatal(1, "fifo: DEPTH must be a power of two >= 2");
    end

    if (READ_CYCLES > RC_REG) begin : g_bad_rc
        $fatal(1, "fifo: READ_CYCLES must be 0 or 1");
    end

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 push;
    logic                 pop;
    logic                 rd_adv;
    logic                 ram_re;
    logic [BIT_WIDTH-1:0] ram_rdata;

    // Flags come from the registered count only, so a same-cycle pop
    // never opens room for a push into a full fifo.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign push = in_valid && !full;
    assign pop  = out_enable && out_valid;

    assign out_data = ram_rdata;

    fifo_ram #(
        .BIT_WIDTH  (BIT_WIDTH),
        .DEPTH      (DEPTH),
        .READ_CYCLES(READ_CYCLES)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(in_data),
        .re_i   (ram_re),
        .raddr_i(rd_ptr_q),
        .rdata_o(ram_rdata)
    );

    if (READ_CYCLES == RC_COMB) begin : g_comb_head
        // Head is read straight out of storage at rd_ptr.
        assign out_valid = !empty;
        assign rd_adv    = pop;
        assign ram_re    = 1'b0;
    end else begin : g_reg_head
        logic out_valid_q, out_valid_d;
        logic stored;

        // Words still sitting in RAM, i.e. not yet loaded into the head.
        assign stored = count_q > {{AW{1'b0}}, out_valid_q};

        // Prefetch whenever the head is free or leaving this cycle; this
        // keeps one pop per cycle sustainable once primed.
        assign ram_re = stored && (!out_valid_q || pop);
        assign rd_adv = ram_re;

        always_comb begin
            out_valid_d = out_valid_q;
            if (ram_re) begin
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_d;
            end
        end

        assign out_valid = out_valid_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: checks fifo with READ_CYCLES=0 and 1 side by side (DEPTH=8).
// Vector table, directed corner sequences and a random scoreboard run.
module tb_fifo;

    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv [2];
    logic [W-1:0] id [2];
    logic         oe [2];
    logic         ov [2];
    logic [W-1:0] od [2];
    logic         fl [2];
    logic         em [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo #(.BIT_WIDTH(W), .DEPTH(D), .READ_CYCLES(0)) u_rc0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_data(id[0]), .out_enable(oe[0]),
        .out_valid(ov[0]), .out_data(od[0]),
        .full(fl[0]), .empty(em[0])
    );

    fifo #(.BIT_WIDTH(W), .DEPTH(D), .READ_CYCLES(1)) u_rc1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_data(id[1]), .out_enable(oe[1]),
        .out_valid(ov[1]), .out_data(od[1]),
        .full(fl[1]), .empty(em[1])
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         oe;
        logic         ov0;
        logic         ov1;
        logic         em;
        logic         fl;
        logic [W-1:0] xd;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        int           t;
    } ent_t;

    vec_t tv [$];
    ent_t mq [2][$];

    task automatic chkb(input string nm, input int i,
                        input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s rc%0d: got %b want %b", nm, i, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input int i,
                        input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s rc%0d: got %h want %h", nm, i, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d,
                         input logic e);
        for (int i = 0; i < 2; i++) begin
            iv[i] = v;
            id[i] = d;
            oe[i] = e;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [W-1:0] d,
                                input logic e, input logic o0,
                                input logic o1, input logic m,
                                input logic f, input logic [W-1:0] x);
        vec_t r;
        r.iv  = v;
        r.d   = d;
        r.oe  = e;
        r.ov0 = o0;
        r.ov1 = o1;
        r.em  = m;
        r.fl  = f;
        r.xd  = x;
        return r;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         expv;
        logic         v;
        logic         e;
        logic [W-1:0] rd;
        logic         pacc [2];
        logic         wacc [2];
        logic [W-1:0] sgot [2][24];
        int           scnt [2];
        int           gaps [2];
        bit           started [2];
        bit           sawfull [2];
        int           nxt;
        int           ecnt;
        int           phase;
        int           pprob;
        int           qprob;

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chkb("reset ov", i, ov[i], 1'b0);
            chkb("reset em", i, em[i], 1'b1);
            chkb("reset fl", i, fl[i], 1'b0);
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b1);
        step();
        for (int i = 0; i < 2; i++) begin
            chkb("pop empty ov", i, ov[i], 1'b0);
            chkb("pop empty em", i, em[i], 1'b1);
            chkb("pop empty fl", i, fl[i], 1'b0);
        end

        // ---------------- vector table ----------------
        tv.push_back(mk(1'b1, 32'hA5A5_0001, 1'b0,
                        1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001));
        tv.push_back(mk(1'b0, '0, 1'b0,
                        1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001));
        tv.push_back(mk(1'b0, '0, 1'b1,
                        1'b0, 1'b0, 1'b1, 1'b0, '0));
        tv.push_back(mk(1'b0, '0, 1'b1,
                        1'b0, 1'b0, 1'b1, 1'b0, '0));
        for (int k = 1; k <= 8; k++) begin
            tv.push_back(mk(1'b1, 32'(k), 1'b0,
                            1'b1, (k >= 2), 1'b0, (k == 8), 32'd1));
        end
        tv.push_back(mk(1'b1, 32'd9, 1'b0,
                        1'b1, 1'b1, 1'b0, 1'b1, 32'd1));
        tv.push_back(mk(1'b1, 32'd9, 1'b1,
                        1'b1, 1'b1, 1'b0, 1'b0, 32'd2));
        for (int k = 3; k <= 8; k++) begin
            tv.push_back(mk(1'b0, '0, 1'b1,
                            1'b1, 1'b1, 1'b0, 1'b0, 32'(k)));
        end
        tv.push_back(mk(1'b0, '0, 1'b1,
                        1'b0, 1'b0, 1'b1, 1'b0, '0));

        foreach (tv[n]) begin
            drive(tv[n].iv, tv[n].d, tv[n].oe);
            step();
            for (int i = 0; i < 2; i++) begin
                expv = (i == 0) ? tv[n].ov0 : tv[n].ov1;
                chkb($sformatf("tbl%0d ov", n), i, ov[i], expv);
                chkb($sformatf("tbl%0d em", n), i, em[i], tv[n].em);
                chkb($sformatf("tbl%0d fl", n), i, fl[i], tv[n].fl);
                if (expv) begin
                    chkw($sformatf("tbl%0d data", n), i, od[i], tv[n].xd);
                end
            end
        end

        // ---------------- streaming wrap ----------------
        nxt = 0;
        for (int i = 0; i < 2; i++) begin
            scnt[i]    = 0;
            gaps[i]    = 0;
            started[i] = 1'b0;
            sawfull[i] = 1'b0;
        end
        for (int c = 0; c < 40; c++) begin
            drive(nxt < 24, 32'(nxt), 1'b1);
            for (int i = 0; i < 2; i++) begin
                if (ov[i]) begin
                    if (scnt[i] < 24) sgot[i][scnt[i]] = od[i];
                    scnt[i]++;
                    started[i] = 1'b1;
                end else if (started[i] && scnt[i] < 24) begin
                    gaps[i]++;
                end
                if (fl[i]) sawfull[i] = 1'b1;
            end
            if (nxt < 24) nxt++;
            step();
        end
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chkw("stream count", i, 32'(scnt[i]), 32'd24);
            for (int k = 0; k < 24; k++) begin
                if (k < scnt[i]) begin
                    chkw($sformatf("stream word%0d", k), i,
                         sgot[i][k], 32'(k));
                end
            end
            chkw("stream gaps", i, 32'(gaps[i]), 32'd0);
            chkb("stream full seen", i, sawfull[i], 1'b0);
            chkb("stream em", i, em[i], 1'b1);
        end

        // ---------------- reset mid-stream ----------------
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h10 + 32'(k), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chkb("midrst pre em", i, em[i], 1'b0);
        end
        rst = 1'b1;
        drive(1'b1, 32'h99, 1'b1);
        step();
        rst = 1'b0;
        drive(1'b1, 32'h77, 1'b0);
        step();
        for (int i = 0; i < 2; i++) scnt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, '0, 1'b1);
            for (int i = 0; i < 2; i++) begin
                if (ov[i]) begin
                    if (scnt[i] < 24) sgot[i][scnt[i]] = od[i];
                    scnt[i]++;
                end
            end
            step();
        end
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chkw("midrst pops", i, 32'(scnt[i]), 32'd1);
            if (scnt[i] > 0) begin
                chkw("midrst word", i, sgot[i][0], 32'h77);
            end
            chkb("midrst em", i, em[i], 1'b1);
            chkb("midrst ov", i, ov[i], 1'b0);
        end

        // ---------------- random vs scoreboard ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        ecnt = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            phase = (cyc / 500) % 3;
            pprob = (phase == 0) ? 80 : (phase == 1) ? 25 : 55;
            qprob = (phase == 0) ? 25 : (phase == 1) ? 80 : 55;
            v  = ($urandom_range(0, 99) < pprob);
            e  = ($urandom_range(0, 99) < qprob);
            rd = $urandom;
            drive(v, rd, e);
            for (int i = 0; i < 2; i++) begin
                // Registered head: a word is presentable only from the
                // edge after the one that wrote it.
                expv = (mq[i].size() > 0) &&
                       ((i == 0) || (mq[i][0].t < ecnt));
                chkb("rnd ov", i, ov[i], expv);
                chkb("rnd em", i, em[i], mq[i].size() == 0);
                chkb("rnd fl", i, fl[i], mq[i].size() == D);
                if (expv) begin
                    chkw("rnd data", i, od[i], mq[i][0].d);
                end
                pacc[i] = expv && e;
                wacc[i] = v && (mq[i].size() < D);
            end
            step();
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                if (pacc[i]) void'(mq[i].pop_front());
                if (wacc[i]) mq[i].push_back('{d: rd, t: ecnt});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
